// File: rtl/issue_scheduler.sv
// issue_scheduler: dependency-tracking issue buffer with round-robin selection of ready entries.
// Define ISSUE_SCHED_STATS_EN to add saturating issue_count / stall_count outputs.
module issue_entry #(
    parameter int BS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_en,
    input  logic [BS-1:0] alloc_row,
    input  logic          issue_en,
    input  logic          comp_en,
    input  logic [BS-1:0] clr_col,
    output logic          is_free,
    output logic          is_ready,
    output logic          is_issued
);
    typedef enum logic [1:0] {FREE, WAITING, ISSUED} state_t;

    state_t        state, state_nx;
    logic [BS-1:0] row, row_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
            row   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
        end
    end

    // Completing producers drop out of every row on the same edge they free up.
    always_comb begin
        state_nx = state;
        row_nx   = row & ~clr_col;
        case (state)
            FREE:    if (alloc_en) begin
                         state_nx = WAITING;
                         row_nx   = alloc_row;
                     end
            WAITING: if (issue_en) state_nx = ISSUED;
            ISSUED:  if (comp_en) begin
                         state_nx = FREE;
                         row_nx   = '0;
                     end
            default: state_nx = FREE;
        endcase
    end

    assign is_free   = (state == FREE);
    assign is_ready  = (state == WAITING) && (row == '0);
    assign is_issued = (state == ISSUED);
endmodule

module issue_scheduler #(
    parameter  int BS = 16,
    localparam int IW = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [BS-1:0] alloc_dep,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic [IW:0]   occupancy,
    output logic          full,
    output logic          empty
`ifdef ISSUE_SCHED_STATS_EN
    ,
    output logic [15:0]   issue_count,
    output logic [15:0]   stall_count
`endif
);
    logic [BS-1:0] free, ready, issued;
    logic [BS-1:0] alloc_oh, comp_oh, clr_col, alloc_row;
    logic [IW-1:0] rr_ptr;
    logic          alloc_fire, issue_fire, comp_fire;

    always_comb begin
        alloc_index = '0;
        for (int k = BS - 1; k >= 0; k--)
            if (free[k]) alloc_index = IW'(k);
    end

    // Selection looks only at registered entry state and rr_ptr.
    always_comb begin
        logic [IW-1:0] idx;
        idx         = '0;
        issue_valid = 1'b0;
        issue_index = '0;
        for (int i = 0; i < BS; i++) begin
            idx = rr_ptr + IW'(i);
            if (!issue_valid && ready[idx]) begin
                issue_valid = 1'b1;
                issue_index = idx;
            end
        end
    end

    assign alloc_ready = |free;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign comp_fire   = complete_valid && issued[complete_index];
    assign alloc_oh    = {{(BS-1){1'b0}}, 1'b1} << alloc_index;
    assign comp_oh     = {{(BS-1){1'b0}}, 1'b1} << complete_index;
    assign clr_col     = comp_fire ? comp_oh : '0;
    assign alloc_row   = alloc_dep & ~free & ~clr_col & ~alloc_oh;

    for (genvar g = 0; g < BS; g++) begin : g_entry
        issue_entry #(.BS(BS)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .alloc_en (alloc_fire && (alloc_index == IW'(g))),
            .alloc_row(alloc_row),
            .issue_en (issue_fire && (issue_index == IW'(g))),
            .comp_en  (comp_fire && (complete_index == IW'(g))),
            .clr_col  (clr_col),
            .is_free  (free[g]),
            .is_ready (ready[g]),
            .is_issued(issued[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (issue_fire) rr_ptr <= issue_index + 1'b1;
            occupancy <= occupancy + {{IW{1'b0}}, alloc_fire} - {{IW{1'b0}}, comp_fire};
        end
    end

    assign full  = (occupancy == (IW+1)'(BS));
    assign empty = (occupancy == '0);

`ifdef ISSUE_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue_fire && issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
            if (!empty && !issue_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus a randomized run checked against an
// instruction-id reference model (an entry is ready once every producer it named has completed).
module tb_issue_scheduler;
    localparam int BS = 16;
    localparam int MAXID = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [15:0] alloc_dep = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_index;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic        issue_ready = 1'b0;
    logic        complete_valid = 1'b0;
    logic [3:0]  complete_index = '0;
    logic [4:0]  occupancy;
    logic        full, empty;
`ifdef ISSUE_SCHED_STATS_EN
    logic [15:0] issue_count, stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: entry -> instruction id, instruction -> list of producer ids
    int m_state [BS];   // 0 free, 1 waiting, 2 issued
    int m_inst  [BS];
    int m_dep   [BS][BS];
    int m_ndep  [BS];
    bit m_done  [MAXID];
    int m_rr = 0;
    int m_next_id = 0;
    bit m_afire = 0;

    issue_scheduler #(.BS(BS)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_dep     (alloc_dep),
        .alloc_ready   (alloc_ready),
        .alloc_index   (alloc_index),
        .issue_valid   (issue_valid),
        .issue_index   (issue_index),
        .issue_ready   (issue_ready),
        .complete_valid(complete_valid),
        .complete_index(complete_index),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty)
`ifdef ISSUE_SCHED_STATS_EN
        ,
        .issue_count   (issue_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_is_ready(int k);
        if (m_state[k] != 1) return 1'b0;
        for (int j = 0; j < m_ndep[k]; j++)
            if (!m_done[m_dep[k][j]]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_pick();
        for (int i = 0; i < BS; i++)
            if (m_is_ready((m_rr + i) % BS)) return (m_rr + i) % BS;
        return -1;
    endfunction

    function automatic int m_lowfree();
        for (int k = 0; k < BS; k++)
            if (m_state[k] == 0) return k;
        return -1;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int k = 0; k < BS; k++)
            if (m_state[k] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < BS; k++) begin
            m_state[k] = 0;
            m_ndep[k]  = 0;
        end
        m_rr    = 0;
        m_afire = 0;
    endtask

    task automatic model_step();
        int af, ip, ci;
        bit cf;
        af = alloc_valid ? m_lowfree() : -1;
        ip = issue_ready ? m_pick() : -1;
        ci = int'(complete_index);
        cf = complete_valid && (m_state[ci] == 2);
        m_afire = (af >= 0);
        if (af >= 0) begin
            m_ndep[af] = 0;
            for (int k = 0; k < BS; k++)
                if (alloc_dep[k] && m_state[k] != 0 && !(cf && k == ci)) begin
                    m_dep[af][m_ndep[af]] = m_inst[k];
                    m_ndep[af]++;
                end
        end
        if (cf) begin
            m_done[m_inst[ci]] = 1'b1;
            m_state[ci] = 0;
        end
        if (ip >= 0) begin
            m_state[ip] = 2;
            m_rr = (ip + 1) % BS;
        end
        if (af >= 0) begin
            m_state[af] = 1;
            m_inst[af]  = m_next_id;
            m_next_id++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 0; alloc_dep = '0; issue_ready = 0; complete_valid = 0; complete_index = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
        vectors++; if (alloc_index !== 4'd0) begin miscompares++; $display("FAIL reset_alloc_index got %0d exp 0", alloc_index); end
        vectors++; if (issue_valid !== 1'b0 || issue_index !== 4'd0) begin miscompares++; $display("FAIL reset_issue got v=%b i=%0d exp v=0 i=0", issue_valid, issue_index); end
        vectors++; if (full !== 1'b0 || empty !== 1'b1 || occupancy !== 5'd0) begin miscompares++; $display("FAIL reset_occ got full=%b empty=%b occ=%0d exp 0/1/0", full, empty, occupancy); end
        do_reset();
    endtask

    task automatic test_in_order();
        do_reset();
        alloc_valid = 1; alloc_dep = '0; issue_ready = 1;
        vectors++; if (alloc_index !== 4'd0 || issue_valid !== 1'b0) begin miscompares++; $display("FAIL inorder_t0 got ai=%0d iv=%b exp 0/0", alloc_index, issue_valid); end
        tick();
        vectors++; if (alloc_index !== 4'd1 || issue_valid !== 1'b1 || issue_index !== 4'd0) begin miscompares++; $display("FAIL inorder_t1 got ai=%0d iv=%b ii=%0d exp 1/1/0", alloc_index, issue_valid, issue_index); end
        tick();
        vectors++; if (alloc_index !== 4'd2 || issue_valid !== 1'b1 || issue_index !== 4'd1) begin miscompares++; $display("FAIL inorder_t2 got ai=%0d iv=%b ii=%0d exp 2/1/1", alloc_index, issue_valid, issue_index); end
        tick();
        alloc_valid = 0;
        vectors++; if (issue_valid !== 1'b1 || issue_index !== 4'd2 || occupancy !== 5'd3) begin miscompares++; $display("FAIL inorder_t3 got iv=%b ii=%0d occ=%0d exp 1/2/3", issue_valid, issue_index, occupancy); end
        tick();
        issue_ready = 0;
        vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL inorder_drained got iv=%b exp 0", issue_valid); end
    endtask

    task automatic test_dep_wake();
        do_reset();
        alloc_valid = 1; alloc_dep = '0;
        tick();
        alloc_dep = 16'h0001; issue_ready = 1;
        tick();
        alloc_valid = 0;
        vectors++; if (issue_valid !== 1'b0 || alloc_index !== 4'd2) begin miscompares++; $display("FAIL dep_blocked got iv=%b ai=%0d exp 0/2", issue_valid, alloc_index); end
        complete_valid = 1; complete_index = 4'd0;
        tick();
        complete_valid = 0;
        vectors++; if (issue_valid !== 1'b1 || issue_index !== 4'd1 || alloc_index !== 4'd0) begin miscompares++; $display("FAIL dep_wake got iv=%b ii=%0d ai=%0d exp 1/1/0", issue_valid, issue_index, alloc_index); end
        issue_ready = 0;
    endtask

    task automatic test_full();
        do_reset();
        alloc_valid = 1; alloc_dep = '0;
        repeat (BS) tick();
        vectors++; if (full !== 1'b1 || alloc_ready !== 1'b0 || occupancy !== 5'd16 || empty !== 1'b0) begin miscompares++; $display("FAIL full_set got full=%b ar=%b occ=%0d exp 1/0/16", full, alloc_ready, occupancy); end
        tick();
        vectors++; if (occupancy !== 5'd16) begin miscompares++; $display("FAIL full_ignore got occ=%0d exp 16", occupancy); end
        issue_ready = 1;
        repeat (6) tick();
        issue_ready = 0; complete_valid = 1; complete_index = 4'd5;
        tick();
        complete_valid = 0;
        vectors++; if (alloc_ready !== 1'b1 || alloc_index !== 4'd5 || occupancy !== 5'd15 || full !== 1'b0) begin miscompares++; $display("FAIL full_free got ar=%b ai=%0d occ=%0d full=%b exp 1/5/15/0", alloc_ready, alloc_index, occupancy, full); end
        alloc_valid = 0;
    endtask

    task automatic test_round_robin();
        do_reset();
        alloc_valid = 1; alloc_dep = '0;
        tick();
        issue_ready = 1; alloc_dep = 16'h0001;
        tick();
        issue_ready = 0;
        for (int k = 2; k <= 12; k++) begin
            alloc_dep = (k == 3 || k == 7 || k == 12) ? 16'h0000 : 16'h0001;
            tick();
        end
        alloc_valid = 0;
        vectors++; if (issue_valid !== 1'b1 || issue_index !== 4'd3) begin miscompares++; $display("FAIL rr_first got iv=%b ii=%0d exp 1/3", issue_valid, issue_index); end
        tick();
        vectors++; if (issue_index !== 4'd3) begin miscompares++; $display("FAIL rr_hold1 got ii=%0d exp 3", issue_index); end
        tick();
        vectors++; if (issue_index !== 4'd3) begin miscompares++; $display("FAIL rr_hold2 got ii=%0d exp 3", issue_index); end
        issue_ready = 1;
        tick();
        vectors++; if (issue_index !== 4'd7) begin miscompares++; $display("FAIL rr_next7 got ii=%0d exp 7", issue_index); end
        tick();
        vectors++; if (issue_index !== 4'd12) begin miscompares++; $display("FAIL rr_next12 got ii=%0d exp 12", issue_index); end
        complete_valid = 1; complete_index = 4'd0;
        tick();
        complete_valid = 0; issue_ready = 0;
        vectors++; if (issue_valid !== 1'b1 || issue_index !== 4'd1) begin miscompares++; $display("FAIL rr_wrap got iv=%b ii=%0d exp 1/1", issue_valid, issue_index); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        alloc_valid = 1; alloc_dep = '0;
        repeat (6) tick();
        alloc_valid = 0; issue_ready = 1;
        repeat (6) tick();
        issue_ready = 0;
        alloc_valid = 1; alloc_dep = 16'h0020; complete_valid = 1; complete_index = 4'd5;
        vectors++; if (alloc_index !== 4'd6) begin miscompares++; $display("FAIL same_alloc_idx got ai=%0d exp 6", alloc_index); end
        tick();
        alloc_valid = 0; complete_valid = 0;
        vectors++; if (issue_valid !== 1'b1 || issue_index !== 4'd6 || alloc_index !== 4'd5 || occupancy !== 5'd6) begin miscompares++; $display("FAIL same_cycle got iv=%b ii=%0d ai=%0d occ=%0d exp 1/6/5/6", issue_valid, issue_index, alloc_index, occupancy); end
        complete_valid = 1; complete_index = 4'd9;
        tick();
        vectors++; if (occupancy !== 5'd6 || alloc_index !== 4'd5 || issue_index !== 4'd6) begin miscompares++; $display("FAIL comp_free got occ=%0d ai=%0d ii=%0d exp 6/5/6", occupancy, alloc_index, issue_index); end
        complete_index = 4'd6;
        tick();
        complete_valid = 0;
        vectors++; if (occupancy !== 5'd6 || issue_valid !== 1'b1 || issue_index !== 4'd6) begin miscompares++; $display("FAIL comp_waiting got occ=%0d iv=%b ii=%0d exp 6/1/6", occupancy, issue_valid, issue_index); end
    endtask

    task automatic test_random();
        int ea, ei, eo, r;
        int lst[$];
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            ea = m_lowfree(); ei = m_pick(); eo = m_occ();
            vectors++; if (alloc_ready !== (ea >= 0)) begin miscompares++; $display("FAIL rnd_alloc_ready c=%0d got %b exp %b", c, alloc_ready, ea >= 0); end
            if (ea >= 0) begin
                vectors++; if (alloc_index !== 4'(ea)) begin miscompares++; $display("FAIL rnd_alloc_index c=%0d got %0d exp %0d", c, alloc_index, ea); end
            end
            vectors++; if (issue_valid !== (ei >= 0)) begin miscompares++; $display("FAIL rnd_issue_valid c=%0d got %b exp %b", c, issue_valid, ei >= 0); end
            if (ei >= 0) begin
                vectors++; if (issue_index !== 4'(ei)) begin miscompares++; $display("FAIL rnd_issue_index c=%0d got %0d exp %0d", c, issue_index, ei); end
            end
            vectors++; if (occupancy !== 5'(eo) || full !== (eo == BS) || empty !== (eo == 0)) begin miscompares++; $display("FAIL rnd_occ c=%0d got occ=%0d full=%b empty=%b exp occ=%0d", c, occupancy, full, empty, eo); end
            // requester holds an unaccepted offer unchanged
            if (!alloc_valid || m_afire) begin
                alloc_valid = ($urandom_range(0, 99) < 60);
                alloc_dep   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            end
            issue_ready = ($urandom_range(0, 99) < 70);
            complete_valid = 0; complete_index = '0;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                lst.delete();
                for (int k = 0; k < BS; k++) if (m_state[k] == 2) lst.push_back(k);
                if (lst.size() > 0) begin
                    complete_valid = 1;
                    complete_index = 4'(lst[$urandom_range(0, lst.size() - 1)]);
                end
            end else if (r == 5) begin
                complete_valid = 1;
                complete_index = 4'($urandom_range(0, BS - 1));
            end
            tick();
        end
        alloc_valid = 0; issue_ready = 0; complete_valid = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_valid = 1; alloc_dep = '0; issue_ready = 1;
        repeat (3) tick();
        alloc_valid = 0; issue_ready = 0;
        vectors++; if (occupancy !== 5'd3) begin miscompares++; $display("FAIL midrst_pre got occ=%0d exp 3", occupancy); end
        @(posedge clk);
        #3 rst = 1;
        #1;
        vectors++; if (occupancy !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL midrst_occ got occ=%0d empty=%b full=%b exp 0/1/0", occupancy, empty, full); end
        vectors++; if (alloc_ready !== 1'b1 || alloc_index !== 4'd0 || issue_valid !== 1'b0 || issue_index !== 4'd0) begin miscompares++; $display("FAIL midrst_out got ar=%b ai=%0d iv=%b ii=%0d exp 1/0/0/0", alloc_ready, alloc_index, issue_valid, issue_index); end
        tick();
        rst = 0;
        complete_valid = 1; complete_index = 4'd0;
        tick();
        complete_valid = 0;
        vectors++; if (occupancy !== 5'd0 || alloc_index !== 4'd0) begin miscompares++; $display("FAIL midrst_stale_comp got occ=%0d ai=%0d exp 0/0", occupancy, alloc_index); end
    endtask

`ifdef ISSUE_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        alloc_valid = 1; alloc_dep = '0; issue_ready = 1;
        repeat (3) tick();
        alloc_valid = 0;
        tick();
        issue_ready = 0;
        repeat (4) tick();
        vectors++; if (issue_count !== 16'd3 || stall_count !== 16'd4) begin miscompares++; $display("FAIL stats got ic=%0d sc=%0d exp 3/4", issue_count, stall_count); end
        do_reset();
        vectors++; if (issue_count !== 16'd0 || stall_count !== 16'd0) begin miscompares++; $display("FAIL stats_reset got ic=%0d sc=%0d exp 0/0", issue_count, stall_count); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_dep_wake();
        test_full();
        test_round_robin();
        test_same_cycle();
        test_random();
        test_mid_reset();
`ifdef ISSUE_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
